// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command FIFO in front of an 8-bit ALU. Each command is
// issued on its own, the ALU is given ALU_LAT clock edges to produce its
// result, and the result is then held on a valid/ready port until it is taken.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [WIDTH-1:0]        cmd_a,
  input  logic [WIDTH-1:0]        cmd_b,
  input  logic [1:0]              cmd_modo,
  output logic                    alu_en,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [1:0]              alu_modo,
  input  logic [WIDTH-1:0]        alu_c,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH-1:0]        res_data,
  output logic [1:0]              res_modo,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAT  = CW'(ALU_LAT);

  typedef struct packed {
    logic [1:0]       modo;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  state_t          state_q, state_d;
  logic            push, issue, capture, clear_res;

  // cmd_ready comes only from the registered count, so a pop in the same
  // cycle never opens a full FIFO early.
  assign cmd_ready  = rst && (count_q < FULL);
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr];
  assign fifo_count = count_q;
  assign busy       = rst && ((state_q != S_IDLE) || (count_q != '0));

  // FIFO storage; validity is tracked by the pointers and count alone
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{modo: cmd_modo, b: cmd_b, a: cmd_a};
  end

  // FIFO pointers and occupancy; the FSM issue is the only pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      case ({push, issue})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state: issue from IDLE, or straight from HOLD on the result handshake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    capture   = 1'b0;
    clear_res = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          clear_res = 1'b1;
          if (count_q != '0) begin
            issue   = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (issue) cnt_d = LAT;
  end

  // State and latency counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU drive: operands latch on issue and stay put until the next issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_en   <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_modo <= '0;
    end else begin
      if (issue) begin
        alu_en   <= 1'b1;
        alu_a    <= head.a;
        alu_b    <= head.b;
        alu_modo <= head.modo;
      end else if (capture) begin
        alu_en   <= 1'b0;
      end
    end
  end

  // Result port: capture alu_c at the end of the wait, hold until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_modo  <= '0;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= alu_c;
        res_modo  <= alu_modo;
      end else if (clear_res) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a registered-ALU instance (ALU_LAT=1) driven
// by directed and random commands and checked through a result scoreboard,
// plus a combinational-ALU instance (ALU_LAT=0) for the zero-latency build.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // ---- ALU_LAT=1 instance signals
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [1:0] cmd_modo;
  logic       alu_en;
  logic [7:0] alu_a, alu_b, alu_c;
  logic [1:0] alu_modo;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [1:0] res_modo;
  logic [2:0] fifo_count;
  logic       busy;

  // ---- ALU_LAT=0 instance signals
  logic       cmd_valid0, cmd_ready0;
  logic [7:0] cmd_a0, cmd_b0;
  logic [1:0] cmd_modo0;
  logic       alu_en0;
  logic [7:0] alu_a0, alu_b0, alu_c0;
  logic [1:0] alu_modo0;
  logic       res_valid0, res_ready0;
  logic [7:0] res_data0;
  logic [1:0] res_modo0;
  logic [2:0] fifo_count0;
  logic       busy0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int en_cnt = 0, en_cnt0 = 0;

  typedef struct { logic [7:0] data; logic [1:0] modo; } exp_t;
  exp_t exp_q[$];

  logic rand_ready  = 1'b0;
  logic ready_force = 1'b0;

  // Reference ALU behaviour: add, sub, mul, shift-left, truncated to 8 bits
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] m);
    logic [15:0] w;
    case (m)
      2'd0:    w = {8'h0, a} + {8'h0, b};
      2'd1:    w = {8'h0, a} - {8'h0, b};
      2'd2:    w = {8'h0, a} * {8'h0, b};
      default: w = {8'h0, a} << b;
    endcase
    return w[7:0];
  endfunction

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_modo(cmd_modo), .alu_en(alu_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_modo(alu_modo), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_modo(res_modo), .fifo_count(fifo_count), .busy(busy));

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(0), .WIDTH(8)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_a(cmd_a0), .cmd_b(cmd_b0), .cmd_modo(cmd_modo0), .alu_en(alu_en0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_modo(alu_modo0), .alu_c(alu_c0),
    .res_valid(res_valid0), .res_ready(res_ready0), .res_data(res_data0),
    .res_modo(res_modo0), .fifo_count(fifo_count0), .busy(busy0));

  // One-stage registered ALU and a purely combinational one
  always @(posedge clk) alu_c <= alu_ref(alu_a, alu_b, alu_modo);
  assign alu_c0 = alu_ref(alu_a0, alu_b0, alu_modo0);

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (alu_en)  en_cnt  = en_cnt + 1;
    if (alu_en0) en_cnt0 = en_cnt0 + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // res_ready driver: random back-pressure or a forced level
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      res_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: occupancy sanity, hold stability, and in-order result scoreboard
  logic       hold_chk = 1'b0;
  logic [7:0] hold_data;
  logic [1:0] hold_modo;
  always @(negedge clk) begin
    if (rst) begin
      if (hold_chk) begin
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_data",  32'(res_data),  32'(hold_data));
        check("hold_modo",  32'(res_modo),  32'(hold_modo));
      end
      hold_chk  = res_valid && !res_ready;
      hold_data = res_data;
      hold_modo = res_modo;
      check("ready_vs_count", 32'(cmd_ready), 32'(fifo_count < 3'd4));
      check("count_bound", 32'((int'(fifo_count) <= exp_q.size()) &&
                               (int'(fifo_count) + 1 >= exp_q.size()) &&
                               (busy == (exp_q.size() != 0))), 32'd1);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_data", 32'(res_data), 32'(e.data));
          check("res_modo", 32'(res_modo), 32'(e.modo));
        end
      end
    end else begin
      hold_chk = 1'b0;
    end
  end

  // Offer one command; called and returns just after a rising edge
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    int n;
    cmd_a = a; cmd_b = b; cmd_modo = m; cmd_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready || n > 500) break;
      @(posedge clk); #1;
      n++;
    end
    check("push_timeout", 32'(n > 500), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_q.push_back('{data: alu_ref(a, b, m), modo: m});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic pushes_done;

  initial begin
    int c0, n, gap;
    logic [1:0] m;
    rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_modo = '0;
    cmd_valid0 = 1'b0; cmd_a0 = '0; cmd_b0 = '0; cmd_modo0 = '0; res_ready0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_alu_en", 32'(alu_en), 32'd0);
    rst = 1'b1;
    ready_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single add: latency and enable width
    en_cnt = 0;
    push(8'h0A, 8'h05, 2'd0);
    c0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 50);
    check("t1_latency", 32'(cyc - c0), 32'd3);
    check("t1_data", 32'(res_data), 32'h0F);
    check("t1_modo", 32'(res_modo), 32'd0);
    wait_drain();
    check("t1_en_cycles", 32'(en_cnt), 32'd2);

    // Back-to-back sub, mul, mul, shl
    push(8'h09, 8'h03, 2'd1);
    push(8'h0A, 8'h05, 2'd2);
    push(8'h09, 8'h03, 2'd2);
    push(8'h09, 8'h03, 2'd3);
    wait_drain();

    // Back-pressure: fill FIFO, then release with a pop against a full FIFO
    ready_force = 1'b0;
    pushes_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) push(8'(i + 1), 8'(i + 2), 2'(i));
        pushes_done = 1'b1;
      end
    join_none
    n = 0;
    do begin @(negedge clk); n++; end
      while (!(fifo_count == 3'd4 && cmd_valid && res_valid) && n < 100);
    check("full_reached", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    ready_force = 1'b1;
    @(negedge clk);
    check("pop_full_valid", 32'(res_valid && res_ready), 32'd1);
    check("pop_full_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("after_pop_ready", 32'(cmd_ready), 32'd1);
    n = 0;
    while (!pushes_done && n < 200) begin @(negedge clk); n++; end
    check("pushes_done", 32'(pushes_done), 32'd1);
    @(posedge clk); #1;
    wait_drain();

    // Random commands under random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(0, 3));
      push(8'($urandom), (m == 2'd3) ? 8'($urandom_range(0, 7)) : 8'($urandom), m);
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end
    wait_drain();
    rand_ready = 1'b0;
    ready_force = 1'b1;
    @(posedge clk); #1;

    // Reset during WAIT with two entries queued
    push(8'h11, 8'h22, 2'd0);
    push(8'h33, 8'h44, 2'd1);
    push(8'h55, 8'h66, 2'd2);
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    check("pre_rst_alu_en", 32'(alu_en), 32'd1);
    #1 rst = 1'b0;
    #1;
    exp_q.delete();
    check("arst_out", 32'({alu_en, alu_a, alu_b, alu_modo, res_valid}), 32'd0);
    check("arst_res", 32'({res_data, res_modo, fifo_count}), 32'd0);
    check("arst_busy_ready", 32'({busy, cmd_ready}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;

    // Combinational-ALU build: overflowing add plus a few random ops
    for (int i = 0; i < 5; i++) begin
      logic [7:0] a, b;
      a = (i == 0) ? 8'hFF : 8'($urandom);
      b = (i == 0) ? 8'h01 : 8'($urandom_range(0, 7));
      m = (i == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      cmd_a0 = a; cmd_b0 = b; cmd_modo0 = m; cmd_valid0 = 1'b1;
      @(negedge clk);
      check("l0_ready", 32'(cmd_ready0), 32'd1);
      @(posedge clk); #1;
      cmd_valid0 = 1'b0;
      c0 = cyc;
      en_cnt0 = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!res_valid0 && n < 50);
      check("l0_latency", 32'(cyc - c0), 32'd2);
      check("l0_data", 32'(res_data0), 32'(alu_ref(a, b, m)));
      check("l0_modo", 32'(res_modo0), 32'(m));
      check("l0_en_cycles", 32'(en_cnt0), 32'd1);
      repeat (2) @(negedge clk);
      check("l0_idle", 32'({busy0, res_valid0, fifo_count0}), 32'd0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream feeder for the 8-bit ALU (modes 00 add, 01 sub, 10 mul, 11 shift-left).
- Buffers operation commands in a small FIFO.
- Issues one command at a time to the ALU (drives a, b, MODO, en), waits a fixed ALU latency, captures the ALU result c, and presents it on a valid/ready result port.
- Replaces hand-sequenced stimulus as the ALU's operand source in the datapath.

Parameters:
DEPTH, 4, command FIFO depth in entries (power of 2, >= 2)
ALU_LAT, 1, clock edges after the operand-presenting cycle before alu_c is valid (0 = combinational ALU)
WIDTH, 8, operand/result width

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst  in  1  asynchronous active-low reset: low clears all state immediately; release is sampled on clk
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept
cmd_a  in  WIDTH  operand a
cmd_b  in  WIDTH  operand b
cmd_modo  in  2  operation mode
alu_en  out  1  ALU enable
alu_a  out  WIDTH  operand a to ALU
alu_b  out  WIDTH  operand b to ALU
alu_modo  out  2  mode to ALU
alu_c  in  WIDTH  ALU result
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  WIDTH  captured result
res_modo  out  2  mode that produced res_data
fifo_count  out  clog2(DEPTH)+1  entries in FIFO
busy  out  1  high when FSM is not IDLE or fifo_count != 0

Behaviour:
- Reset (rst low): FIFO flushed, rd/wr pointers 0, FSM = IDLE, wait counter 0.
  - Registered outputs forced to 0: alu_en, alu_a, alu_b, alu_modo, res_valid, res_data, res_modo, fifo_count.
  - busy = 0 and cmd_ready = 0 while rst low.
  - Reset mid-operation aborts the in-flight command; no result is produced.
- FIFO:
  - cmd_ready = (fifo_count < DEPTH), combinational from the registered count.
  - Push on cmd_valid & cmd_ready. Pop only on an FSM issue.
  - Push and pop in the same cycle: count unchanged.
  - When full, cmd_ready = 0 even if a pop occurs that cycle (no bypass).
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, fifo_count > 0: at the next edge, pop head, register alu_a/alu_b/alu_modo, set alu_en = 1, load counter = ALU_LAT, go WAIT.
  - IDLE, fifo_count = 0: stay; alu_en = 0; alu_a/b/modo hold last values.
  - WAIT: alu_en = 1; operands held stable.
    - Counter > 0: decrement each edge.
    - Counter = 0: at that edge, capture alu_c into res_data, alu_modo into res_modo; res_valid = 1; alu_en = 0; go HOLD.
  - HOLD: res_valid, res_data, res_modo stable until res_ready is sampled high.
    - On the handshake edge: res_valid = 0.
    - If fifo_count > 0, issue next head in the same edge (as IDLE) and go WAIT; else go IDLE.
- Latency, empty FIFO and res_ready high:
  - Command accepted at edge N; issue at edge N+1; alu_c sampled at edge N+1+ALU_LAT+1; res_valid high after that edge.
  - ALU_LAT=1: 3 edges from accept to res_valid.
- Arithmetic: no computation in this block. res_data is alu_c as sampled (ALU already truncates to WIDTH). Operands pass through unmodified.
- Only one command is in flight at a time. Commands complete in FIFO order.

Test Plan:
1. Reset, then push {a=0x0A, b=0x05, modo=00}, res_ready=1 -> alu_en high for ALU_LAT+1 cycles; res_valid after 3 edges from accept; res_data=0x0F, res_modo=00.
2. Back-to-back push of sub (0x09, 0x03), mul (0x0A, 0x05), mul (0x09, 0x03), shl (0x09, 0x03) -> results in order 0x06, 0x32, 0x1B, 0x48; fifo_count never exceeds 4.
3. Hold res_ready=0 and push 5 commands -> cmd_ready drops to 0 when fifo_count = 4; first result held stable; raising res_ready drains all results in order.
4. FIFO full while a pop occurs in the same cycle -> cmd_ready remains 0 that cycle; the offered command is accepted the following cycle; no entry lost or duplicated.
5. Assert rst low during WAIT with 2 entries queued -> all outputs 0 immediately (asynchronously); after release fifo_count=0, busy=0, no res_valid ever produced for aborted commands.
6. ALU_LAT=0 build with a combinational ALU model: add 0xFF+0x01 -> res_data=0x00, res_valid 2 edges after accept.
